// File: rtl/d_kes_cs_pkg.sv
// Shared types and output-layout helpers for the KES -> Chien-search staging buffer.
package d_kes_cs_pkg;

    typedef enum logic {
        BANK_A = 1'b0,
        BANK_B = 1'b1
    } bank_sel_t;

    function automatic bank_sel_t other_bank(input bank_sel_t b);
        return (b == BANK_A) ? BANK_B : BANK_A;
    endfunction

    // Bit offset of coefficient j of chunk k in the wide ELP burst (field 0 at MSB).
    function automatic int coef_ofs(input int multi, input int gfd, input int elpc,
                                    input int j, input int k);
        return gfd * multi * (elpc - 1 - j) + gfd * k;
    endfunction

    // Bit offset of the error count of chunk k in the count burst.
    function automatic int cnt_ofs(input int mecb, input int k);
        return mecb * k;
    endfunction

endpackage

// File: rtl/d_kes_cs_pingpong_buffer_if.sv
// KES write side and CS read side of the ping-pong buffer, bundled as one interface.
interface d_kes_cs_pingpong_buffer_if #(
    parameter int Multi             = 4,
    parameter int GaloisFieldDegree = 12,
    parameter int MaxErrorCountBits = 9,
    parameter int ELPCoefficients   = 15,
    parameter int ChunkNumBits      = 2
);
    logic                                                 i_exe_buf;
    logic                                                 i_kes_fail;
    logic                                                 i_buf_sequence_end;
    logic [ChunkNumBits-1:0]                              i_chunk_number;
    logic [MaxErrorCountBits-1:0]                         i_error_count;
    logic [GaloisFieldDegree*ELPCoefficients-1:0]         i_ELP_coef;
    logic                                                 i_cs_available;
    logic                                                 o_buf_available;
    logic                                                 o_drop;
    logic                                                 o_exe_cs;
    logic [Multi-1:0]                                     o_kes_sequence_end;
    logic [Multi-1:0]                                     o_kes_fail;
    logic [Multi*MaxErrorCountBits-1:0]                   o_error_count;
    logic [Multi*GaloisFieldDegree*ELPCoefficients-1:0]   o_ELP_coef;

    modport master (
        output i_exe_buf, i_kes_fail, i_buf_sequence_end, i_chunk_number,
               i_error_count, i_ELP_coef, i_cs_available,
        input  o_buf_available, o_drop, o_exe_cs, o_kes_sequence_end,
               o_kes_fail, o_error_count, o_ELP_coef
    );

    modport slave (
        input  i_exe_buf, i_kes_fail, i_buf_sequence_end, i_chunk_number,
               i_error_count, i_ELP_coef, i_cs_available,
        output o_buf_available, o_drop, o_exe_cs, o_kes_sequence_end,
               o_kes_fail, o_error_count, o_ELP_coef
    );
endinterface

// File: rtl/d_kes_cs_bank.sv
// One bank of the ping-pong buffer: per-chunk slot registers plus a seal bit,
// presented already rearranged into the wide CS burst layout.
module d_kes_cs_bank
    import d_kes_cs_pkg::*;
#(
    parameter int Multi             = 4,
    parameter int GaloisFieldDegree = 12,
    parameter int MaxErrorCountBits = 9,
    parameter int ELPCoefficients   = 15,
    parameter int ChunkNumBits      = 2
) (
    input  logic                                                i_clk,
    input  logic                                                i_RESET,
    input  logic                                                i_wr,
    input  logic [ChunkNumBits-1:0]                             i_wr_slot,
    input  logic                                                i_wr_fail,
    input  logic [MaxErrorCountBits-1:0]                        i_wr_count,
    input  logic [GaloisFieldDegree*ELPCoefficients-1:0]        i_wr_coef,
    input  logic                                                i_seal,
    input  logic                                                i_clr,
    output logic                                                o_sealed,
    output logic [Multi-1:0]                                    o_en,
    output logic [Multi-1:0]                                    o_fail,
    output logic [Multi*MaxErrorCountBits-1:0]                  o_count,
    output logic [Multi*GaloisFieldDegree*ELPCoefficients-1:0]  o_coef
);
    localparam int GFD  = GaloisFieldDegree;
    localparam int ELPC = ELPCoefficients;
    localparam int MECB = MaxErrorCountBits;

    always_ff @(posedge i_clk) begin
        if (i_RESET || i_clr) o_sealed <= 1'b0;
        else if (i_seal)      o_sealed <= 1'b1;
    end

    for (genvar k = 0; k < Multi; k++) begin : g_slot
        logic                  hit;
        logic                  en_q;
        logic                  fail_q;
        logic [MECB-1:0]       cnt_q;
        logic [GFD*ELPC-1:0]   coef_q;

        assign hit = i_wr && (i_wr_slot == ChunkNumBits'(k));

        // A failed chunk still enables CS so the fail flag travels with the burst.
        always_ff @(posedge i_clk) begin
            if (i_RESET || i_clr) begin
                en_q   <= 1'b0;
                fail_q <= 1'b0;
                cnt_q  <= '0;
                coef_q <= '0;
            end else if (hit) begin
                en_q   <= i_wr_fail | (|i_wr_count);
                fail_q <= i_wr_fail;
                cnt_q  <= i_wr_fail ? '0 : i_wr_count;
                coef_q <= i_wr_fail ? '0 : i_wr_coef;
            end
        end

        assign o_en[k]   = en_q;
        assign o_fail[k] = fail_q;
        assign o_count[cnt_ofs(MECB, k) +: MECB] = cnt_q;

        for (genvar j = 0; j < ELPC; j++) begin : g_coef
            assign o_coef[coef_ofs(Multi, GFD, ELPC, j, k) +: GFD] =
                coef_q[GFD*(ELPC-j)-1 -: GFD];
        end
    end

endmodule

// File: rtl/d_kes_cs_pingpong_buffer.sv
// Double-banked KES -> Chien-search staging buffer: KES fills one bank while the
// other sealed bank waits for CS, which receives it as a single registered burst.
module d_kes_cs_pingpong_buffer
    import d_kes_cs_pkg::*;
#(
    parameter int Multi             = 4,
    parameter int GaloisFieldDegree = 12,
    parameter int MaxErrorCountBits = 9,
    parameter int ELPCoefficients   = 15,
    parameter int ChunkNumBits      = 2
) (
    input  logic                             i_clk,
    input  logic                             i_RESET,
    input  logic                             i_stop_dec,
    d_kes_cs_pingpong_buffer_if.slave        bus
);
    localparam int CW = GaloisFieldDegree * ELPCoefficients;

    bank_sel_t wr_sel, rd_sel;
    logic      wr_idx, rd_idx;
    logic      rst;
    logic      buf_avail, in_rng, accept, wr, seal, drain, drop_nxt;

    logic [1:0]                                   b_sealed;
    logic [1:0][Multi-1:0]                        b_en;
    logic [1:0][Multi-1:0]                        b_fail;
    logic [1:0][Multi*MaxErrorCountBits-1:0]      b_cnt;
    logic [1:0][Multi*CW-1:0]                     b_coef;

    assign rst    = i_RESET | i_stop_dec;
    assign wr_idx = wr_sel;
    assign rd_idx = rd_sel;

    assign buf_avail = !b_sealed[wr_idx];
    assign in_rng    = int'(bus.i_chunk_number) < Multi;
    assign accept    = bus.i_exe_buf && buf_avail;
    assign wr        = accept && in_rng;
    // Sequence end seals the bank even when the slot index itself is rejected.
    assign seal      = accept && bus.i_buf_sequence_end;
    assign drain     = b_sealed[rd_idx] && bus.i_cs_available && !rst;
    assign drop_nxt  = bus.i_exe_buf && !(buf_avail && in_rng);

    assign bus.o_buf_available = buf_avail;

    always_ff @(posedge i_clk) begin
        if (rst) begin
            wr_sel <= BANK_A;
            rd_sel <= BANK_A;
        end else begin
            if (seal)  wr_sel <= other_bank(wr_sel);
            if (drain) rd_sel <= other_bank(rd_sel);
        end
    end

    for (genvar b = 0; b < 2; b++) begin : g_bank
        d_kes_cs_bank #(
            .Multi             (Multi),
            .GaloisFieldDegree (GaloisFieldDegree),
            .MaxErrorCountBits (MaxErrorCountBits),
            .ELPCoefficients   (ELPCoefficients),
            .ChunkNumBits      (ChunkNumBits)
        ) u_bank (
            .i_clk      (i_clk),
            .i_RESET    (rst),
            .i_wr       (wr && (wr_idx == 1'(b))),
            .i_wr_slot  (bus.i_chunk_number),
            .i_wr_fail  (bus.i_kes_fail),
            .i_wr_count (bus.i_error_count),
            .i_wr_coef  (bus.i_ELP_coef),
            .i_seal     (seal && (wr_idx == 1'(b))),
            .i_clr      (drain && (rd_idx == 1'(b))),
            .o_sealed   (b_sealed[b]),
            .o_en       (b_en[b]),
            .o_fail     (b_fail[b]),
            .o_count    (b_cnt[b]),
            .o_coef     (b_coef[b])
        );
    end

    // Burst registers are zero whenever no burst is being presented.
    always_ff @(posedge i_clk) begin
        if (rst || !drain) begin
            bus.o_exe_cs           <= 1'b0;
            bus.o_kes_sequence_end <= '0;
            bus.o_kes_fail         <= '0;
            bus.o_error_count      <= '0;
            bus.o_ELP_coef         <= '0;
        end else begin
            bus.o_exe_cs           <= 1'b1;
            bus.o_kes_sequence_end <= b_en[rd_idx];
            bus.o_kes_fail         <= b_fail[rd_idx];
            bus.o_error_count      <= b_cnt[rd_idx];
            bus.o_ELP_coef         <= b_coef[rd_idx];
        end
    end

    always_ff @(posedge i_clk) begin
        if (rst) bus.o_drop <= 1'b0;
        else     bus.o_drop <= drop_nxt;
    end

endmodule

// File: tb/tb_d_kes_cs_pingpong_buffer.sv
// Directed bench for the KES -> CS ping-pong buffer (Multi=4, 3-bit chunk index).
module tb_d_kes_cs_pingpong_buffer;
    localparam int Multi = 4, GFD = 12, MECB = 9, ELPC = 15, CNB = 3;
    localparam int CW = GFD * ELPC;
    localparam int OW = Multi * CW;

    logic i_clk = 1'b0;
    logic i_RESET = 1'b1;
    logic i_stop_dec = 1'b0;
    int   n_chk = 0, n_fail = 0;
    logic [CW-1:0] sq [Multi];

    always #5 i_clk = ~i_clk;

    d_kes_cs_pingpong_buffer_if #(
        .Multi(Multi), .GaloisFieldDegree(GFD), .MaxErrorCountBits(MECB),
        .ELPCoefficients(ELPC), .ChunkNumBits(CNB)
    ) bus ();

    d_kes_cs_pingpong_buffer #(
        .Multi(Multi), .GaloisFieldDegree(GFD), .MaxErrorCountBits(MECB),
        .ELPCoefficients(ELPC), .ChunkNumBits(CNB)
    ) dut (
        .i_clk      (i_clk),
        .i_RESET    (i_RESET),
        .i_stop_dec (i_stop_dec),
        .bus        (bus)
    );

    task automatic chk(input string tag, input logic [767:0] act, input logic [767:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic step();
        @(posedge i_clk);
        #1;
    endtask

    function automatic logic [CW-1:0] pat(input int salt, input int k);
        logic [CW-1:0] v = '0;
        for (int j = 0; j < ELPC; j++) v[GFD*(ELPC-j)-1 -: GFD] = 12'((salt << 8) | (k << 4) | j);
        return v;
    endfunction

    // Expected burst: coef j of chunk k lands in field j (field 0 at MSB), lane k.
    function automatic logic [OW-1:0] elp_exp();
        logic [OW-1:0] v = '0;
        for (int k = 0; k < Multi; k++)
            for (int j = 0; j < ELPC; j++)
                v[GFD*Multi*(ELPC-1-j) + GFD*k +: GFD] = sq[k][GFD*(ELPC-j)-1 -: GFD];
        return v;
    endfunction

    task automatic clr_sq();
        for (int k = 0; k < Multi; k++) sq[k] = '0;
    endtask

    task automatic wr(input int ch, input int cnt, input bit fail, input bit last, input logic [CW-1:0] coef);
        bus.i_exe_buf          = 1'b1;
        bus.i_chunk_number     = CNB'(ch);
        bus.i_error_count      = MECB'(cnt);
        bus.i_kes_fail         = fail;
        bus.i_buf_sequence_end = last;
        bus.i_ELP_coef         = coef;
        step();
        bus.i_exe_buf          = 1'b0;
        bus.i_kes_fail         = 1'b0;
        bus.i_buf_sequence_end = 1'b0;
    endtask

    initial begin
        bus.i_exe_buf = 1'b0; bus.i_kes_fail = 1'b0; bus.i_buf_sequence_end = 1'b0;
        bus.i_chunk_number = '0; bus.i_error_count = '0; bus.i_ELP_coef = '0;
        bus.i_cs_available = 1'b0;
        step(); step();
        i_RESET = 1'b0;
        chk("rst_exe_cs", bus.o_exe_cs, 1'b0);
        chk("rst_avail", bus.o_buf_available, 1'b1);
        chk("rst_drop", bus.o_drop, 1'b0);
        chk("rst_seq_end", bus.o_kes_sequence_end, 4'b0000);
        chk("rst_fail", bus.o_kes_fail, 4'b0000);
        chk("rst_cnt", bus.o_error_count, 36'h0);
        chk("rst_elp", bus.o_ELP_coef, 720'h0);

        // Full sequence, CS ready: burst appears two cycles after the seal.
        bus.i_cs_available = 1'b1;
        clr_sq();
        for (int k = 0; k < Multi; k++) sq[k] = pat(1, k);
        wr(0, 3, 0, 0, sq[0]);
        wr(1, 0, 0, 0, sq[1]);
        wr(2, 2, 0, 0, sq[2]);
        wr(3, 1, 0, 1, sq[3]);
        chk("t1_no_early_cs", bus.o_exe_cs, 1'b0);
        step();
        chk("t1_exe_cs", bus.o_exe_cs, 1'b1);
        chk("t1_seq_end", bus.o_kes_sequence_end, 4'b1101);
        chk("t1_fail", bus.o_kes_fail, 4'b0000);
        chk("t1_cnt", bus.o_error_count, {9'd1, 9'd2, 9'd0, 9'd3});
        chk("t1_elp", bus.o_ELP_coef, elp_exp());
        step();
        chk("t1_single_pulse", bus.o_exe_cs, 1'b0);
        chk("t1_elp_idle", bus.o_ELP_coef, 720'h0);

        // KES failure on chunk 2: enabled, flagged, data zeroed.
        wr(2, 5, 1, 1, pat(2, 2));
        step();
        chk("t2_exe_cs", bus.o_exe_cs, 1'b1);
        chk("t2_fail", bus.o_kes_fail, 4'b0100);
        chk("t2_seq_end", bus.o_kes_sequence_end, 4'b0100);
        chk("t2_cnt", bus.o_error_count, 36'h0);
        chk("t2_elp", bus.o_ELP_coef, 720'h0);
        step();

        // Backpressure: two sealed banks, then drain in seal order.
        bus.i_cs_available = 1'b0;
        wr(0, 7, 0, 1, pat(3, 0));
        wr(1, 4, 0, 1, pat(4, 1));
        chk("t3_full_avail", bus.o_buf_available, 1'b0);
        wr(0, 1, 0, 0, pat(5, 0));
        chk("t3_drop_full", bus.o_drop, 1'b1);
        step();
        chk("t3_drop_pulse", bus.o_drop, 1'b0);
        chk("t3_no_cs", bus.o_exe_cs, 1'b0);
        bus.i_cs_available = 1'b1;
        wr(3, 2, 0, 0, pat(6, 3));
        clr_sq(); sq[0] = pat(3, 0);
        chk("t3_burst1", bus.o_exe_cs, 1'b1);
        chk("t3_drop_drain", bus.o_drop, 1'b1);
        chk("t3_avail_back", bus.o_buf_available, 1'b1);
        chk("t3_seq_end1", bus.o_kes_sequence_end, 4'b0001);
        chk("t3_cnt1", bus.o_error_count, 36'd7);
        chk("t3_elp1", bus.o_ELP_coef, elp_exp());
        step();
        clr_sq(); sq[1] = pat(4, 1);
        chk("t3_burst2", bus.o_exe_cs, 1'b1);
        chk("t3_seq_end2", bus.o_kes_sequence_end, 4'b0010);
        chk("t3_cnt2", bus.o_error_count, {9'd0, 9'd0, 9'd4, 9'd0});
        chk("t3_elp2", bus.o_ELP_coef, elp_exp());
        step();
        chk("t3_done", bus.o_exe_cs, 1'b0);

        // Out-of-range chunk with sequence end: dropped but still seals.
        clr_sq(); sq[1] = pat(7, 1);
        wr(1, 6, 0, 0, sq[1]);
        wr(5, 9, 0, 1, pat(8, 1));
        chk("t4_drop", bus.o_drop, 1'b1);
        step();
        chk("t4_exe_cs", bus.o_exe_cs, 1'b1);
        chk("t4_seq_end", bus.o_kes_sequence_end, 4'b0010);
        chk("t4_cnt", bus.o_error_count, {9'd0, 9'd0, 9'd6, 9'd0});
        chk("t4_elp", bus.o_ELP_coef, elp_exp());
        step();

        // Abort with one bank sealed and the other half filled.
        bus.i_cs_available = 1'b0;
        wr(0, 3, 0, 1, pat(9, 0));
        wr(1, 2, 0, 0, pat(9, 1));
        chk("t5_avail_pre", bus.o_buf_available, 1'b1);
        i_stop_dec = 1'b1;
        bus.i_cs_available = 1'b1;
        step();
        i_stop_dec = 1'b0;
        chk("t5_exe_cs", bus.o_exe_cs, 1'b0);
        chk("t5_avail", bus.o_buf_available, 1'b1);
        chk("t5_seq_end", bus.o_kes_sequence_end, 4'b0000);
        chk("t5_drop", bus.o_drop, 1'b0);
        for (int i = 0; i < 3; i++) begin
            step();
            chk("t5_no_cs_after", bus.o_exe_cs, 1'b0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/d_kes_cs_pingpong_buffer.md
# d_kes_cs_pingpong_buffer

Double-banked, parametrised staging buffer between the KES (key-equation solver) array and the Chien-search (CS) block. It collects per-chunk ELP coefficients, error counts and fail flags for up to `Multi` chunks of one page sequence. It presents them to CS as one wide, one-cycle `o_exe_cs` burst. Two banks let KES fill the next sequence while the previous sealed sequence waits for CS.

## Interface
Parameters:
- `Multi`, 4: chunks per sequence (≥2)
- `GaloisFieldDegree`, 12: symbol width
- `MaxErrorCountBits`, 9: error-count width
- `ELPCoefficients`, 15: coefficients per ELP
- `ChunkNumBits`, 2: width of chunk index; ≥ clog2(`Multi`), minimum 1

Ports:
- `i_clk` in 1: clock
- `i_RESET` in 1: reset, synchronous, active-high; clock `i_clk`
- `i_stop_dec` in 1: synchronous abort, same effect as reset
- `i_exe_buf` in 1: write strobe, one chunk result
- `i_kes_fail` in 1: KES failed for this chunk
- `i_buf_sequence_end` in 1: this write is the last of the sequence
- `i_chunk_number` in `ChunkNumBits`: target slot
- `i_error_count` in `MaxErrorCountBits`: error count
- `i_ELP_coef` in `GaloisFieldDegree*ELPCoefficients`: coefficient j at bits [GFD*(ELPC-j)-1 : GFD*(ELPC-j-1)] (coef 0 at MSB)
- `i_cs_available` in 1: CS can accept a burst
- `o_buf_available` out 1: write bank open
- `o_drop` out 1: one-cycle pulse, write discarded
- `o_exe_cs` out 1: one-cycle burst valid
- `o_kes_sequence_end` out `Multi`: per-chunk CS enable
- `o_kes_fail` out `Multi`: per-chunk fail
- `o_error_count` out `Multi*MaxErrorCountBits`: chunk k at [MECB*(k+1)-1 : MECB*k]
- `o_ELP_coef` out `Multi*GFD*ELPC`: coefficient j occupies field j (field 0 at MSB, each `Multi*GFD` wide); chunk k at [GFD*(k+1)-1 : GFD*k] within the field

## Operation
- Two banks, A and B. Each bank holds per-slot {en, fail, count, coef} plus a `sealed` bit. Pointers `wr_sel` and `rd_sel` both reset to A; the banks form a depth-2 FIFO.
- `o_buf_available = !sealed[wr_sel]` (from registers only).
- A write is accepted when `i_exe_buf && o_buf_available && i_chunk_number < Multi`. For slot k of bank `wr_sel`:
  - if `i_kes_fail`: fail[k]=1, en[k]=1, count[k]=0, coef[k]=0
  - otherwise: fail[k]=0, en[k]=|`i_error_count`, and count[k] and coef[k] load from the inputs
  - last write to a slot wins; untouched slots stay zero
- Sealing: if `i_exe_buf && o_buf_available && i_buf_sequence_end`, the bank is sealed and `wr_sel` toggles. This applies even when the chunk index is out of range; in that case the slot write is skipped.
- Dropped writes:
  - `i_exe_buf` with `o_buf_available=0`: no state change, `o_drop` pulses next cycle
  - `i_exe_buf` with `i_chunk_number ≥ Multi`: `o_drop` pulses next cycle
- Drain: if `sealed[rd_sel] && i_cs_available`, the next edge does the following:
  - registers the bank onto the outputs with `o_exe_cs=1`
  - clears that bank entirely (slots and seal)
  - toggles `rd_sel`
- While `o_exe_cs=0`, all data outputs are 0.
- Sealing one bank and draining the other in the same cycle is legal; both take effect.
- `i_RESET` or `i_stop_dec`: both banks and both pointers clear, every output goes to 0, and `o_buf_available`=1 in the following cycle. Any bank mid-fill or awaiting drain is discarded.

## Timing
- Reset values: `o_exe_cs`, `o_kes_sequence_end`, `o_kes_fail`, `o_error_count`, `o_ELP_coef`, `o_drop` = 0; `o_buf_available`=1.
- Write at cycle t → slot visible at t+1.
- Seal at t, `i_cs_available` high at t+1 → `o_exe_cs` high exactly in cycle t+2. This is minimum latency 2.
- `o_exe_cs` is never high two consecutive cycles for the same bank. Back-to-back sealed banks with CS available produce `o_exe_cs` in consecutive cycles.
- With both banks sealed, `o_buf_available`=0. It returns to 1 in the cycle after the drain of bank `wr_sel`. A write in the drain cycle itself is dropped.
- `i_cs_available` is sampled only when `sealed[rd_sel]`=1. It is a level signal, not a pulse.

## Structure
- Shared package `d_kes_cs_pkg`:
  - bank index type (A/B)
  - function returning the output bit offsets for (coef j, chunk k) and (count, chunk k)
- Sub-module `d_kes_cs_bank`, instantiated twice:
  - one bank's slot registers and seal bit
  - write/clear ports
  - packed output bus in the `o_ELP_coef` layout
- The top holds the pointers, availability logic, drop logic and the registered output stage.

## Test plan
- Multi=4, writes to chunks 0..3 with counts 3,0,2,1, unique coef patterns, last with sequence_end; `i_cs_available`=1 → `o_exe_cs` at seal+2, `o_kes_sequence_end`=4'b1101, counts and coefs at the specified offsets.
- Chunk 2 written with `i_kes_fail`=1, then sealed → `o_kes_fail`=4'b0100, `o_kes_sequence_end[2]`=1, chunk 2 count and coefs 0.
- `i_cs_available`=0, two sequences sealed → `o_buf_available`=0, third write gives `o_drop` pulse. Raise `i_cs_available` → two consecutive bursts in seal order; `o_buf_available` returns after the first.
- Write with `i_chunk_number`=5 (ChunkNumBits=3, Multi=4) plus sequence_end → `o_drop`=1, bank still sealed and drained with slot data unchanged.
- Assert `i_stop_dec` while one bank is sealed and the other half-filled → next cycle all outputs 0, `o_buf_available`=1, no `o_exe_cs` afterwards even with `i_cs_available`=1.
